// File: rtl/tlc5957_tx.sv
// tlc5957_tx: SCLK/SIN/LAT serial transmitter for TLC5957 FC writes and grayscale frames.
module tlc5957_tx #(
  parameter int DIV = 2,
  parameter int GS_BITS = 9,
  parameter int LEDS = 16,
  parameter int GAP = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [47:0]                 fc_data,
  input  logic                        fc_valid,
  output logic                        fc_ready,
  input  logic [LEDS*3*GS_BITS-1:0]   gs_data,
  input  logic                        gs_valid,
  output logic                        gs_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        SCLK,
  output logic                        SIN,
  output logic                        LAT
);
  localparam int CH = LEDS * 3;
  localparam int NB = CH * GS_BITS;
  localparam int CW = $clog2(NB + 1);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam int HW = $clog2(CH);
  typedef enum logic [1:0] {IDLE, FC_SHIFT, GS_SHIFT, GAP_WAIT} state_t;
  state_t        state;
  logic [PW-1:0] phase;
  logic [CW-1:0] cnt;
  logic [HW-1:0] ch;
  logic [GW-1:0] gcnt;
  logic [NB-1:0] sr, gs_sr;
  logic          tick, fall, last, lat_nx;
  assign tick     = phase == PW'(DIV - 1);
  assign fall     = tick & SCLK;
  assign fc_ready = state == IDLE;
  assign gs_ready = state == IDLE;
  assign last     = cnt == (state == FC_SHIFT ? CW'(48) : CW'(NB));
  assign lat_nx   = state == FC_SHIFT ? (cnt < CW'(15) || cnt >= CW'(43))
                                      : (ch == '0 || (cnt >= CW'(NB - CH) && ch < HW'(3)));
  // Transpose the frame so the shift register MSB is bit b=GS_BITS-1 of the top channel.
  for (genvar b = 0; b < GS_BITS; b++) begin : g_b
    for (genvar c = 0; c < CH; c++) begin : g_c
      assign gs_sr[b*CH+c] = gs_data[c*GS_BITS+b];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      cnt   <= '0;
      ch    <= '0;
      gcnt  <= '0;
      sr    <= '0;
      SCLK  <= 1'b0;
      SIN   <= 1'b0;
      LAT   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      phase <= tick ? '0 : phase + 1'b1;
      SCLK  <= SCLK ^ tick;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= fc_valid | gs_valid;
          if (fc_valid | gs_valid) begin
            state <= fc_valid ? FC_SHIFT : GS_SHIFT;
            sr    <= fc_valid ? NB'(fc_data) << (NB - 48) : gs_sr;
            cnt   <= '0;
            ch    <= HW'(CH - 1);
          end
        end
        FC_SHIFT, GS_SHIFT: if (fall) begin
          if (last) begin
            state <= GAP_WAIT;
            SIN   <= 1'b0;
            LAT   <= 1'b0;
            gcnt  <= '0;
          end else begin
            SIN <= sr[NB-1];
            LAT <= lat_nx;
            sr  <= sr << 1;
            cnt <= cnt + 1'b1;
            ch  <= ch == '0 ? HW'(CH - 1) : ch - 1'b1;
          end
        end
        default: if (fall) begin
          state <= gcnt == GW'(GAP - 1) ? IDLE : GAP_WAIT;
          done  <= gcnt == GW'(GAP - 1);
          gcnt  <= gcnt + 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_tlc5957_tx.sv
// tb_tlc5957_tx: random and directed FC/GS transfers checked against a bit-stream model of the driver.
module tb_tlc5957_tx;
  localparam int DIV = 3, GS_BITS = 9, LEDS = 16, GAP = 10;
  localparam int NB = LEDS * 3 * GS_BITS, GSW = NB;
  localparam int LIMIT = (NB + GAP + 2) * 2 * DIV + 20;
  localparam logic [47:0] FC_SPEC = {2'b01, 2'b01, 1'b1, 1'b1, 5'b0, 3'b0, 9'h100, 9'h100, 9'h100,
                                     3'b100, 1'b1, 3'b0};
  logic clk = 0, rst_n;
  logic [47:0] fc_data;
  logic [GSW-1:0] gs_data;
  logic fc_valid, gs_valid, fc_ready, gs_ready, busy, done, SCLK, SIN, LAT;
  int n_chk = 0, n_pass = 0, done_n = 0, stab_bad = 0, per_bad = 0, cyc = 0, last_rise = -1;
  logic bq[$], lq[$];
  bit p_sclk, p_sin, p_lat, p_rst;

  tlc5957_tx #(.DIV(DIV), .GS_BITS(GS_BITS), .LEDS(LEDS), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .fc_data(fc_data), .fc_valid(fc_valid), .fc_ready(fc_ready),
    .gs_data(gs_data), .gs_valid(gs_valid), .gs_ready(gs_ready), .busy(busy), .done(done),
    .SCLK(SCLK), .SIN(SIN), .LAT(LAT));

  always #5 clk = ~clk;

  // Driver-side view: capture SIN/LAT on every SCLK rise, watch timing rules.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) last_rise = -1;
    else begin
      if (SCLK && !p_sclk) begin
        bq.push_back(SIN);
        lq.push_back(LAT);
        if (last_rise >= 0 && cyc - last_rise != 2 * DIV) per_bad++;
        last_rise = cyc;
      end
      if ((SIN != p_sin || LAT != p_lat) && !(p_sclk && !SCLK) && p_rst) stab_bad++;
      if (done) done_n++;
    end
    p_sclk = SCLK; p_sin = SIN; p_lat = LAT; p_rst = rst_n;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [GSW-1:0] rand_gs();
    logic [GSW-1:0] v;
    for (int i = 0; i < GSW; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  task automatic start(input bit fv, input bit gv, input logic [47:0] f, input logic [GSW-1:0] g);
    @(negedge clk);
    fc_data = f; gs_data = g; fc_valid = fv; gs_valid = gv;
    @(posedge clk); #1;
    bq.delete(); lq.delete(); done_n = 0;
    fc_valid = 0;
    if (!(fv && gv)) gs_valid = 0;
    fc_data = {$urandom, $urandom};
    if (!gs_valid) gs_data = rand_gs();
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < LIMIT) begin @(negedge clk); k++; end
    check("done_timeout", k < LIMIT, 1);
    @(posedge clk); #1;
  endtask

  task automatic verify(input string tag, input bit fc, input logic [47:0] f, input logic [GSW-1:0] g);
    int n, tot, off, lat_hi, lat_err, tail, i;
    logic [47:0] fw;
    logic [GSW-1:0] rb;
    logic s, l, el;
    n = fc ? 48 : NB; tot = bq.size(); off = tot - GAP - n;
    lat_hi = 0; lat_err = 0; tail = 0; fw = '0; rb = '0; i = 0;
    check({tag, "_rises"}, off == 0 || off == 1, 1);
    if (off < 0) off = 0;
    if (fc) for (int k = 0; k < 48; k++) begin
      s = off + k < tot ? bq[off+k] : 1'bx;
      l = off + k < tot ? lq[off+k] : 1'bx;
      fw = {fw[46:0], s};
      el = k < 15 || k >= 43;
      if (l === 1'b1) lat_hi++;
      if (l !== el) lat_err++;
    end
    else for (int b = GS_BITS - 1; b >= 0; b--)
      for (int led = LEDS - 1; led >= 0; led--)
        for (int c = 2; c >= 0; c--) begin
          s = off + i < tot ? bq[off+i] : 1'bx;
          l = off + i < tot ? lq[off+i] : 1'bx;
          rb[(3*led+c)*GS_BITS+b] = s;
          el = (3 * led + c == 0) || (b == 0 && 3 * led + c < 3);
          if (l === 1'b1) lat_hi++;
          if (l !== el) lat_err++;
          i++;
        end
    for (int k = off + n; k < tot; k++) if (bq[k] !== 1'b0 || lq[k] !== 1'b0) tail++;
    if (fc) check({tag, "_word"}, fw, f);
    else check({tag, "_frame"}, rb === g, 1);
    check({tag, "_lat_cnt"}, lat_hi, fc ? 20 : GS_BITS + 2);
    check({tag, "_lat_pos"}, lat_err, 0);
    check({tag, "_gap"}, tail, 0);
    check({tag, "_done"}, done_n, 1);
  endtask

  initial begin
    int k, w;
    logic [47:0] f;
    logic [GSW-1:0] g, g2, pat;
    for (int led = 0; led < LEDS; led++)
      for (int c = 0; c < 3; c++) pat[(led*3+c)*GS_BITS +: GS_BITS] = {4'(led), 1'b0, 4'(c + 1)};
    fc_data = '0; gs_data = '0; fc_valid = 0; gs_valid = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", {SCLK, SIN, LAT, busy, done}, 0);
    check("rst_ready", {fc_ready, gs_ready}, 2'b11);
    rst_n = 1;
    start(1, 0, FC_SPEC, '0);
    check("busy_after_accept", busy, 1);
    wait_done(k);
    verify("fc_spec", 1, FC_SPEC, '0);
    check("idle_busy", {busy, done}, 0);
    start(0, 1, '0, pat);
    wait_done(k);
    check("gs_len", k >= (NB + GAP) * 2 * DIV && k <= (NB + GAP + 1) * 2 * DIV + 1, 1);
    verify("gs_pat", 0, '0, pat);
    repeat (2) begin
      f = {$urandom, $urandom}; g = rand_gs();
      start(1, 0, f, '0); wait_done(k); verify("fc_rand", 1, f, '0);
      start(0, 1, '0, g); wait_done(k); verify("gs_rand", 0, '0, g);
    end
    f = {$urandom, $urandom}; g = rand_gs();
    start(1, 1, f, g);
    check("both_gs_ready", gs_ready, 0);
    wait_done(k);
    verify("both_fc", 1, f, '0);
    check("both_gs_accepted", busy, 1);
    bq.delete(); lq.delete(); done_n = 0;
    gs_valid = 0; gs_data = rand_gs();
    wait_done(k);
    verify("both_gs", 0, '0, g);
    g = rand_gs(); g2 = ~g;
    start(0, 1, '0, g);
    gs_valid = 1; gs_data = g2;
    w = 0;
    while (bq.size() < 300 && w < LIMIT) begin @(negedge clk); w++; end
    check("hold_gs_ready", gs_ready, 0);
    gs_valid = 0;
    wait_done(k);
    verify("hold_gs", 0, '0, g);
    start(0, 1, '0, rand_gs());
    w = 0;
    while (bq.size() < 201 && w < LIMIT) begin @(negedge clk); w++; end
    check("bit200_reached", bq.size() >= 201, 1);
    #2 rst_n = 0;
    #1 check("async_rst_outs", {SCLK, SIN, LAT, busy}, 0);
    check("async_rst_ready", {fc_ready, gs_ready}, 2'b11);
    repeat (2) @(negedge clk);
    rst_n = 1;
    g = rand_gs();
    start(0, 1, '0, g);
    wait_done(k);
    verify("gs_after_rst", 0, '0, g);
    check("sin_lat_stable", stab_bad, 0);
    check("sclk_period", per_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
